// File: rtl/mux4_reg.sv
// mux4_reg
// Registered 4-to-1 word multiplexer for the expression-solver datapath.
// One of four equal-width operand buses is chosen by a 2-bit select and
// loaded into an output register when en is high. Alongside the data, the
// block reports when a load happened (valid) and whether the load used a
// different source than the previous load (chg).
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   en     : load enable, the output register only updates when en=1
//   in1    : channel 0 data (M=2'b00)
//   in2    : channel 1 data (M=2'b01)
//   in3    : channel 2 data (M=2'b10)
//   in4    : channel 3 data (M=2'b11)
//   M      : channel select
//   MX     : registered selected word
//   valid  : high for exactly the cycle after each enabled load
//   sel_q  : select value captured at the last enabled load
//   chg    : one-cycle pulse when a load used a different M than the last one
module mux4_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [1:0]       M,
    output logic [WIDTH-1:0] MX,
    output logic             valid,
    output logic [1:0]       sel_q,
    output logic             chg
);

    logic [WIDTH-1:0] mux_s;
    logic             chg_s;
    logic [WIDTH-1:0] mx_r;
    logic [1:0]       sel_r;
    logic             valid_r;
    logic             chg_r;

    // Combinational select of the candidate word for the next load.
    always_comb begin
        mux_s = in1;
        case (M)
            2'b00:   mux_s = in1;
            2'b01:   mux_s = in2;
            2'b10:   mux_s = in3;
            2'b11:   mux_s = in4;
            default: mux_s = in1;
        endcase
    end

    // Source-change detection compares against the select of the previous
    // load; after reset that is 2'b00, so a first load from in1 is no change.
    always_comb begin
        chg_s = 1'b0;
        if (M != sel_r) begin
            chg_s = 1'b1;
        end else begin
            chg_s = 1'b0;
        end
    end

    // Output register: loads on en, otherwise holds data and clears the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mx_r    <= {WIDTH{1'b0}};
            sel_r   <= 2'b00;
            valid_r <= 1'b0;
            chg_r   <= 1'b0;
        end else if (en) begin
            mx_r    <= mux_s;
            sel_r   <= M;
            valid_r <= 1'b1;
            chg_r   <= chg_s;
        end else begin
            mx_r    <= mx_r;
            sel_r   <= sel_r;
            valid_r <= 1'b0;
            chg_r   <= 1'b0;
        end
    end

    assign MX    = mx_r;
    assign sel_q = sel_r;
    assign valid = valid_r;
    assign chg   = chg_r;

endmodule

// File: tb/tb_mux4_reg.sv
module tb_mux4_reg;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [15:0] in3;
    logic [15:0] in4;
    logic [1:0]  M;
    logic [15:0] MX;
    logic        valid;
    logic [1:0]  sel_q;
    logic        chg;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] mx;
        logic [1:0]  sel;
        logic        vld;
        logic        chg;
    } exp_t;

    exp_t sb[$];

    // reference state of the bench's behavioural model
    logic [15:0] m_mx;
    logic [1:0]  m_sel;

    mux4_reg #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .in4   (in4),
        .M     (M),
        .MX    (MX),
        .valid (valid),
        .sel_q (sel_q),
        .chg   (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one clock cycle: push the model's expectation, clock, pop and compare.
    task automatic cycle(input logic e, input logic [1:0] m, input string tag);
        exp_t x;
        exp_t got;
        en = e;
        M  = m;
        if (!rst_n) begin
            m_mx  = 16'h0000;
            m_sel = 2'b00;
            x.vld = 1'b0;
            x.chg = 1'b0;
        end else if (e) begin
            x.chg = (m != m_sel);
            case (m)
                2'b00:   m_mx = in1;
                2'b01:   m_mx = in2;
                2'b10:   m_mx = in3;
                default: m_mx = in4;
            endcase
            m_sel = m;
            x.vld = 1'b1;
        end else begin
            x.vld = 1'b0;
            x.chg = 1'b0;
        end
        x.mx  = m_mx;
        x.sel = m_sel;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, "_mx"},    {16'h0000, MX},           {16'h0000, got.mx});
        chk({tag, "_sel"},   {30'h0, sel_q},           {30'h0, got.sel});
        chk({tag, "_valid"}, {31'h0, valid},           {31'h0, got.vld});
        chk({tag, "_chg"},   {31'h0, chg},             {31'h0, got.chg});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mx"},    {16'h0000, MX}, 32'h0000_0000);
        chk({tag, "_sel"},   {30'h0, sel_q}, 32'h0000_0000);
        chk({tag, "_valid"}, {31'h0, valid}, 32'h0000_0000);
        chk({tag, "_chg"},   {31'h0, chg},   32'h0000_0000);
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        M     = 2'b00;
        in1   = 16'hFFFF;
        in2   = 16'hDFFF;
        in3   = 16'hBFFF;
        in4   = 16'h7FFF;
        m_mx  = 16'h0000;
        m_sel = 2'b00;

        // Reset asserted between edges with non-zero inputs
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("reset_imm");
        cycle(1'b1, 2'b11, "reset_hold1");
        cycle(1'b1, 2'b10, "reset_hold2");
        #2;
        rst_n = 1'b1;

        // Full decode
        cycle(1'b1, 2'b00, "dec00");
        chk("dec00_const", {16'h0000, MX}, 32'h0000_FFFF);
        chk("dec00_chg0",  {31'h0, chg},   32'h0000_0000);
        cycle(1'b1, 2'b11, "dec11");
        chk("dec11_const", {16'h0000, MX}, 32'h0000_7FFF);
        cycle(1'b1, 2'b10, "dec10");
        chk("dec10_const", {16'h0000, MX}, 32'h0000_BFFF);
        cycle(1'b1, 2'b01, "dec01");
        chk("dec01_const", {16'h0000, MX}, 32'h0000_DFFF);
        chk("dec01_chg1",  {31'h0, chg},   32'h0000_0001);

        // Hold with en=0 while M and in4 move
        cycle(1'b1, 2'b11, "hold_load");
        in4 = 16'h1111;
        cycle(1'b0, 2'b00, "hold1");
        in4 = 16'h2222;
        cycle(1'b0, 2'b01, "hold2");
        in4 = 16'h3333;
        cycle(1'b0, 2'b10, "hold3");
        chk("hold_const", {16'h0000, MX}, 32'h0000_7FFF);
        in4 = 16'h7FFF;

        // Repeat select
        cycle(1'b1, 2'b01, "rep1");
        chk("rep1_chg1", {31'h0, chg}, 32'h0000_0001);
        cycle(1'b1, 2'b01, "rep2");
        chk("rep2_chg0", {31'h0, chg}, 32'h0000_0000);
        chk("rep2_const", {16'h0000, MX}, 32'h0000_DFFF);

        // Reset during an enabled cycle
        en = 1'b1;
        M  = 2'b10;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_op_imm");
        cycle(1'b1, 2'b10, "rst_op_noload");
        #2;
        rst_n = 1'b1;
        cycle(1'b1, 2'b10, "rst_op_reload");
        chk("rst_op_const", {16'h0000, MX}, 32'h0000_BFFF);
        chk("rst_op_chg1",  {31'h0, chg},   32'h0000_0001);

        // Input change right after the sampling edge
        cycle(1'b1, 2'b00, "late_load");
        in1 = 16'h1234;
        cycle(1'b0, 2'b00, "late_hold1");
        cycle(1'b0, 2'b00, "late_hold2");
        chk("late_const", {16'h0000, MX}, 32'h0000_FFFF);
        cycle(1'b1, 2'b00, "late_next");
        chk("late_next_const", {16'h0000, MX}, 32'h0000_1234);

        // Continuous enable keeps valid high
        in2 = 16'hA5A5;
        cycle(1'b1, 2'b01, "cont1");
        in3 = 16'h5A5A;
        cycle(1'b1, 2'b10, "cont2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4_reg.md
# mux4_reg

Registered 4-to-1 word multiplexer for the expression-solver datapath. It selects one of four equal-width operand buses with a 2-bit select and presents the chosen word on a registered output. A valid flag and a selection-change pulse let downstream register and ALU stages track when and from which source the output was loaded.

## Interface
- WIDTH, 16: bit width of each data input and of MX.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  load enable; the output register updates only when en=1.
- in1  input  WIDTH  channel 0 data, selected by M=2'b00.
- in2  input  WIDTH  channel 1 data, selected by M=2'b01.
- in3  input  WIDTH  channel 2 data, selected by M=2'b10.
- in4  input  WIDTH  channel 3 data, selected by M=2'b11.
- M  input  2  channel select.
- MX  output  WIDTH  registered selected word.
- valid  output  1  high for exactly the cycle after each enabled load.
- sel_q  output  2  select value captured at the last enabled load.
- chg  output  1  one-cycle pulse when an enabled load used a different M than the previous load.

## Operation
- Fixed decode:
  - M=00 selects in1.
  - M=01 selects in2.
  - M=10 selects in3.
  - M=11 selects in4.
  - All four codes are legal, and there is no error state.
- On a rising clk edge with en=1:
  - MX takes the selected input.
  - sel_q takes M.
  - valid is set to 1.
  - chg is set to (M != sel_q), using the sel_q value from before the edge.
- On a rising clk edge with en=0:
  - MX and sel_q hold their values.
  - valid and chg are cleared to 0.
- The first enabled load after reset compares M against the reset value sel_q=00. Loading M=00 therefore produces chg=0.
- Data passes through unmodified: no sign extension, no inversion, and WIDTH bits in equal WIDTH bits out.
- Inputs may change at any time. Only their values at the enabled clock edge matter.

## Timing
- Latency is 1 cycle. Inputs and M sampled at edge N appear on MX at edge N and remain stable until the next enabled edge.
- valid and chg assert in the cycle after the sampling edge, last exactly one cycle, and drop at the next edge unless en=1 again.
- With en held high, the output updates every cycle and valid stays high continuously.
- Reset behaviour:
  - rst_n=0 immediately forces MX=0, sel_q=2'b00, valid=0 and chg=0, independent of clk.
  - Outputs stay at these values while rst_n=0.
  - Reset asserted in the same cycle as an enabled load takes priority, and the load is discarded.
  - After rst_n is released, the first rising edge with en=1 performs a normal load.
- Changing M with en=0 has no effect on any output.

## Test plan
- Reset:
  - Drive rst_n=0 between clock edges with inputs non-zero.
  - Required: MX=0x0000, sel_q=00, valid=0 and chg=0 immediately; all outputs hold these values until release.
- Full decode:
  - Inputs: in1=0xFFFF, in2=0xDFFF, in3=0xBFFF, in4=0x7FFF.
  - With en=1, apply M=00, 11, 10, 01 on successive edges.
  - Required: MX is 0xFFFF, 0x7FFF, 0xBFFF, 0xDFFF, each one cycle after its select.
  - Required: sel_q tracks M, and chg=0 on the first load and 1 on the next three.
- Hold:
  - After loading M=11, set en=0 and toggle M and in4 for 3 cycles.
  - Required: MX stays 0x7FFF, sel_q stays 11, and valid=0.
- Repeat select:
  - With en=1, apply M=01 twice.
  - Required: chg=1 on the first load (previous M was 11) and chg=0 on the second; MX=0xDFFF throughout.
- Reset during operation:
  - Assert rst_n=0 mid-cycle while en=1 and M=10.
  - Required: MX=0 immediately and no load at the next edge.
  - After release, load M=10 with in3=0xBFFF. Required: MX=0xBFFF and chg=1.
- Input change after sampling:
  - With M=00, change in1 from 0xFFFF to 0x1234 just after an enabled edge, then hold en=0.
  - Required: MX stays 0xFFFF until the next enabled edge.
